tt_bus_responder: RTL and testbench

//  Target side of the byte-serial 4-phase memory bus driven by the tt_um_aiju CPU core.

---
 rtl/tt_bus_pkg.sv | 35 +++
 rtl/tt_sync_bit.sv | 20 ++
 rtl/tt_bus_responder.sv | 142 ++++++++++++++
 tb/tb_tt_bus_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_bus_pkg.sv
// Shared definitions for the byte-serial 4-phase bus: phase order, op encoding
// and responder FSM states. The initiator imports this too so both ends agree.
package tt_bus_pkg;

    typedef enum logic [1:0] {
        PH_ADDR_LO = 2'd0,
        PH_ADDR_HI = 2'd1,
        PH_DATA    = 2'd2
    } phase_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        ST_WAIT_REQ = 2'd0,
        ST_MEM      = 2'd1,
        ST_ACK      = 2'd2
    } state_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_ADDR_LO: return PH_ADDR_HI;
            PH_ADDR_HI: return PH_DATA;
            default:    return PH_ADDR_LO;
        endcase
    endfunction

    // Conflicting or absent flags fall back to a read, which has no side effects.
    function automatic op_t decode_op(input logic rd, input logic wr);
        return (wr && !rd) ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/tt_sync_bit.sv
// Single-bit synchroniser: STAGES-deep flop chain, async reset to 0.
module tt_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/tt_bus_responder.sv
// Responder for the 3-phase (ADDR_LO, ADDR_HI, DATA) 4-phase handshake bus;
// turns each transfer into one read or write on a simple memory port.
module tt_bus_responder
    import tt_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [7:0]  bus_i,
    output logic        ack_o,
    output logic [7:0]  bus_o,
    output logic        bus_oe,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        proto_err
);

    logic [2:0] async_in, sync_out;
    logic       req_s, rd_s, wr_s;

    assign async_in = {wr_i, rd_i, req_i};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        tt_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (async_in[i]),
            .q     (sync_out[i])
        );
    end

    assign {wr_s, rd_s, req_s} = sync_out;

    state_t      state, state_d;
    phase_t      phase, phase_d;
    op_t         op, op_d;
    logic [15:0] addr_d;
    logic [7:0]  wdata_d, bus_o_d;
    logic        bus_oe_d, perr_d, ack_d, we_d, re_d;
    logic        idle_q, idle_d, abort_cond;

    // Initiator reset mid-transfer: rd/wr both low between phases for 2 cycles.
    assign abort_cond = (phase != PH_ADDR_LO) && !rd_s && !wr_s;

    always_comb begin
        state_d  = state;
        phase_d  = phase;
        op_d     = op;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        bus_o_d  = bus_o;
        bus_oe_d = bus_oe;
        perr_d   = 1'b0;
        idle_d   = 1'b0;
        case (state)
            ST_WAIT_REQ: begin
                idle_d = abort_cond;
                if (abort_cond && idle_q) begin
                    // A req seen now is left pending and taken as ADDR_LO next cycle.
                    phase_d = PH_ADDR_LO;
                end else if (req_s) begin
                    case (phase)
                        PH_ADDR_LO: begin
                            addr_d[7:0] = bus_i;
                            op_d        = decode_op(rd_s, wr_s);
                            perr_d      = rd_s && wr_s;
                            state_d     = ST_ACK;
                        end
                        PH_ADDR_HI: begin
                            addr_d[15:8] = bus_i;
                            state_d      = ST_ACK;
                        end
                        default: begin
                            if (op == OP_WRITE) wdata_d = bus_i;
                            state_d = ST_MEM;
                        end
                    endcase
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (op == OP_READ) begin
                        bus_o_d  = mem_rdata;
                        bus_oe_d = 1'b1;
                    end
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    bus_oe_d = 1'b0;
                    phase_d  = next_phase(phase);
                    state_d  = ST_WAIT_REQ;
                end
            end
            default: state_d = ST_WAIT_REQ;
        endcase
        // Outputs are registered from the next state so they are glitch-free.
        ack_d = (state_d == ST_ACK);
        we_d  = (state_d == ST_MEM) && (op_d == OP_WRITE);
        re_d  = (state_d == ST_MEM) && (op_d == OP_READ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT_REQ;
            phase     <= PH_ADDR_LO;
            op        <= OP_READ;
            mem_addr  <= '0;
            mem_wdata <= '0;
            bus_o     <= '0;
            bus_oe    <= 1'b0;
            proto_err <= 1'b0;
            ack_o     <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            idle_q    <= 1'b0;
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            op        <= op_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            bus_o     <= bus_o_d;
            bus_oe    <= bus_oe_d;
            proto_err <= perr_d;
            ack_o     <= ack_d;
            mem_we    <= we_d;
            mem_re    <= re_d;
            idle_q    <= idle_d;
        end
    end

endmodule

// File: tb/tb_tt_bus_responder.sv
// Directed bench for tt_bus_responder: initiator tasks, memory model and an
// expected-operation scoreboard checked when the DUT issues a memory request.
module tb_tt_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n, req_i, rd_i, wr_i;
    logic [7:0]  bus_i, bus_o, mem_wdata, mem_rdata;
    logic        ack_o, bus_oe, mem_we, mem_re, mem_ready, proto_err;
    logic [15:0] mem_addr;

    tt_bus_responder #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .rd_i      (rd_i),
        .wr_i      (wr_i),
        .bus_i     (bus_i),
        .ack_o     (ack_o),
        .bus_o     (bus_o),
        .bus_oe    (bus_oe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [0:65535];
    int         tests = 0, errors = 0;
    int         mem_delay = 0;
    int         ack_rises = 0, oe_seen = 0, oe_bad = 0, perr_cnt = 0, both_bad = 0;
    logic       ack_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: on the first cycle of a request, pop and compare the scoreboard.
    initial begin : mem_model
        logic busy;
        int   cnt;
        exp_t e;
        busy = 1'b0;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_we || mem_re) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_mem_op", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("op_we", {31'd0, mem_we}, {31'd0, e.wr});
                        check("op_re", {31'd0, mem_re}, {31'd0, !e.wr});
                        check("op_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                        if (e.wr) check("op_wdata", {24'd0, mem_wdata}, {24'd0, e.data});
                    end
                end
                if (cnt >= mem_delay) begin
                    mem_ready = 1'b1;
                    if (mem_re) mem_rdata = model[mem_addr];
                    else        model[mem_addr] = mem_wdata;
                    busy = 1'b0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (ack_o && !ack_prev) ack_rises++;
            ack_prev = ack_o;
            if (bus_oe) oe_seen++;
            if (bus_oe && !ack_o) oe_bad++;
            if (proto_err) perr_cnt++;
            if (mem_we && mem_re) both_bad++;
        end
    end

    task automatic ph_start(input logic [7:0] b, output int lat);
        bus_i = b;
        @(negedge clk);
        req_i = 1'b1;
        lat = 0;
        while (ack_o !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (ack_o !== 1'b1) check("ack_rise_timeout", 32'd0, 32'd1);
    endtask

    task automatic ph_end(output int lat);
        req_i = 1'b0;
        lat = 0;
        while (ack_o !== 1'b0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (ack_o !== 1'b0) check("ack_fall_timeout", 32'd0, 32'd1);
    endtask

    task automatic xfer(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [7:0] data, input int dly,
                        output logic [7:0] rdata, output logic oe, output int dlat);
        int l;
        rd_i = rd;
        wr_i = wr;
        mem_delay = dly;
        sb.push_back('{wr: (wr && !rd), addr: addr, data: data});
        repeat (3) @(negedge clk);
        ph_start(addr[7:0], l);  ph_end(l);
        ph_start(addr[15:8], l); ph_end(l);
        ph_start(data, dlat);
        rdata = bus_o;
        oe = bus_oe;
        ph_end(l);
    endtask

    initial begin : stim
        logic [7:0] rdata;
        logic       oe;
        int         lat, l, base, stuck;

        rst_n = 1'b0; req_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0; bus_i = 8'h00;
        for (int i = 0; i < 65536; i++) model[i] = 8'h00;
        model[16'h00FF] = 8'h3C;
        model[16'h0011] = 8'h77;
        model[16'h0042] = 8'h99;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, ack_o}, 32'd0);
        check("rst_bus_oe", {31'd0, bus_oe}, 32'd0);
        check("rst_bus_o", {24'd0, bus_o}, 32'd0);
        check("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
        check("rst_perr", {31'd0, proto_err}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: write 0xA5 to 0x1234
        base = ack_rises;
        xfer(1'b0, 1'b1, 16'h1234, 8'hA5, 0, rdata, oe, lat);
        check("t1_ack_pulses", ack_rises - base, 32'd3);
        check("t1_oe_never", oe_seen, 32'd0);
        check("t1_mem", {24'd0, model[16'h1234]}, 32'hA5);
        check("t1_data_lat", lat, 32'd4);

        // 2: read 0x00FF, memory 3 cycles late
        xfer(1'b1, 1'b0, 16'h00FF, 8'h00, 3, rdata, oe, lat);
        check("t2_rdata", {24'd0, rdata}, 32'h3C);
        check("t2_oe", {31'd0, oe}, 32'd1);
        check("t2_data_lat", lat, 32'd7);

        // 3: back-to-back write then reads
        xfer(1'b0, 1'b1, 16'hBEEF, 8'h5A, 1, rdata, oe, lat);
        xfer(1'b1, 1'b0, 16'h0011, 8'h00, 0, rdata, oe, lat);
        check("t3_rdata_lo", {24'd0, rdata}, 32'h77);
        check("t3_addr_fresh", {16'd0, mem_addr}, 32'h0011);
        xfer(1'b1, 1'b0, 16'hBEEF, 8'h00, 0, rdata, oe, lat);
        check("t3_readback", {24'd0, rdata}, 32'h5A);

        // 4: req held 20 cycles in ACK
        rd_i = 1'b0; wr_i = 1'b1; mem_delay = 0;
        sb.push_back('{wr: 1'b1, addr: 16'h4321, data: 8'h11});
        repeat (3) @(negedge clk);
        ph_start(8'h21, l);
        stuck = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack_o !== 1'b1) stuck++;
        end
        check("t4_ack_held", stuck, 32'd0);
        ph_end(l);
        check("t4_ack_fall", l, 32'd3);
        ph_start(8'h43, l); ph_end(l);
        ph_start(8'h11, l); ph_end(l);
        check("t4_mem", {24'd0, model[16'h4321]}, 32'h11);

        // 5: abort after ADDR_HI, then a fresh write
        rd_i = 1'b0; wr_i = 1'b1;
        repeat (3) @(negedge clk);
        ph_start(8'h78, l); ph_end(l);
        ph_start(8'h56, l); ph_end(l);
        wr_i = 1'b0;
        repeat (10) @(negedge clk);
        xfer(1'b0, 1'b1, 16'hBCDE, 8'h9A, 0, rdata, oe, lat);
        check("t5_mem", {24'd0, model[16'hBCDE]}, 32'h9A);

        // 6: rd=wr=1 -> error pulse and read; reset during the read's ACK
        base = perr_cnt;
        rd_i = 1'b1; wr_i = 1'b1; mem_delay = 0;
        sb.push_back('{wr: 1'b0, addr: 16'h0042, data: 8'h00});
        repeat (3) @(negedge clk);
        ph_start(8'h42, l); ph_end(l);
        ph_start(8'h00, l); ph_end(l);
        check("t6_perr_pulse", perr_cnt - base, 32'd1);
        ph_start(8'h00, l);
        check("t6_rdata", {24'd0, bus_o}, 32'h99);
        check("t6_oe", {31'd0, bus_oe}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ack", {31'd0, ack_o}, 32'd0);
        check("t6_rst_oe", {31'd0, bus_oe}, 32'd0);
        check("t6_rst_bus_o", {24'd0, bus_o}, 32'd0);
        check("t6_rst_addr", {16'd0, mem_addr}, 32'd0);
        req_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        check("sb_drained", sb.size(), 32'd0);
        check("oe_only_with_ack", oe_bad, 32'd0);
        check("we_re_exclusive", both_bad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
